// File: rtl/fifo_xform_pkg.sv
// Shared encodings for the FIFO-to-FIFO stream transformer: word transform modes and FSM states.
// No logic; imported by fifo_xform and fifo_xform_alu.
// Backpressure behaviour is defined by the users of these types.
package fifo_xform_pkg;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_BSWAP = 2'b10;
    localparam logic [1:0] MODE_BREV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAP  = 3'd2,
        ST_PUSH = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_xform_alu.sv
// Per-word transform: pass / invert / byte-swap / bit-reverse, then XOR with a mask.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module fifo_xform_alu
    import fifo_xform_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] di,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] mask,
    output logic [DW-1:0] result
);

    logic [DW-1:0] xf_dat;

    always_comb begin
        xf_dat = di;
        case (mode)
            MODE_INV: xf_dat = ~di;
            MODE_BSWAP: begin
                for (int b = 0; b < DW / 8; b++) begin
                    xf_dat[b*8 +: 8] = di[(DW/8-1-b)*8 +: 8];
                end
            end
            MODE_BREV: begin
                for (int i = 0; i < DW; i++) begin
                    xf_dat[i] = di[DW-1-i];
                end
            end
            default: xf_dat = di;
        endcase
    end

    assign result = xf_dat ^ mask;

endmodule

// File: rtl/fifo_xform.sv
// On CS, moves LEN words from a source FIFO to a sink FIFO through a selectable transform (XFORM_MASK_EN adds MASK).
// 1 cycle CS->first RD; 3 cycles per word when unstalled; DONE pulses one cycle after the last WR.
// Empty holds the read request; Full holds DO and withholds WR.
module fifo_xform
    import fifo_xform_pkg::*;
#(
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CS,
    input  logic [CNT_W-1:0] LEN,
    input  logic [1:0]       MODE,
`ifdef XFORM_MASK_EN
    input  logic [DW-1:0]    MASK,
`endif
    input  logic             Empty,
    output logic             RD,
    input  logic [DW-1:0]    DI,
    input  logic             Full,
    output logic             WR,
    output logic [DW-1:0]    DO,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       mode_q;
    logic [DW-1:0]    mask_q;
    logic [DW-1:0]    do_q;
    logic [DW-1:0]    xf_dat;
    logic             start;
    logic             last_word;

    assign start     = (state_q == ST_IDLE) && CS;
    assign last_word = (count_q + CNT_W'(1)) == len_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (CS) state_d = (LEN == '0) ? ST_FIN : ST_REQ;
            ST_REQ:  if (!Empty) state_d = ST_CAP;
            ST_CAP:  state_d = ST_PUSH;
            ST_PUSH: if (!Full) state_d = last_word ? ST_FIN : ST_REQ;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are gated by RSTN so a reset mid-burst silences both FIFOs immediately.
    always_comb begin
        RD   = RSTN && (state_q == ST_REQ) && !Empty;
        WR   = RSTN && (state_q == ST_PUSH) && !Full;
        DONE = RSTN && (state_q == ST_FIN);
        BUSY = (state_q != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            len_q   <= '0;
            mode_q  <= MODE_PASS;
            count_q <= '0;
            do_q    <= '0;
        end else begin
            if (start) begin
                len_q   <= LEN;
                mode_q  <= MODE;
                count_q <= '0;
            end
            if (state_q == ST_CAP) do_q <= xf_dat;
            if (WR) count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef XFORM_MASK_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            mask_q <= '0;
        end else if (start) begin
            mask_q <= MASK;
        end
    end
`else
    assign mask_q = '0;
`endif

    fifo_xform_alu #(.DW(DW)) u_alu (
        .di     (DI),
        .mode   (mode_q),
        .mask   (mask_q),
        .result (xf_dat)
    );

    assign DO    = do_q;
    assign COUNT = count_q;

endmodule
